// File: rtl/bram_read_server.sv
// Valid/ready request front end for one port of a write-first BRAM, with a credit-guarded response FIFO.
// Define BRAM_READ_SERVER_BYPASS_EN to forward BRAM_DO straight to the response port when the FIFO is empty.
module bram_read_server #(
  parameter int ADDR_WIDTH        = 1,
  parameter int DATA_WIDTH        = 1,
  parameter int PIPELINED         = 0,
  parameter int DEPTH             = 3,
  parameter int RESPONSE_ON_WRITE = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_DATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic                  BRAM_EN,
  output logic                  BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  input  logic [DATA_WIDTH-1:0] BRAM_DO
);

  localparam int LAT = (PIPELINED != 0) ? 2 : 1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int OW  = $clog2(DEPTH + LAT + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic [LAT-1:0]        trk;
  logic [OW-1:0]         trk_set, occupied;
  logic                  responding, fire, fire_rsp, trk_last;
  logic                  enq, deq, full, empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign responding = !REQ_WRITE || (RESPONSE_ON_WRITE != 0);

  always_comb begin
    trk_set = '0;
    for (int i = 0; i < LAT; i++) trk_set = trk_set + OW'(trk[i]);
  end

  // Credits come only from registered state, so a dequeue frees a slot one cycle later.
  assign occupied  = OW'(count) + trk_set;
  assign REQ_READY = (occupied < OW'(DEPTH)) || !responding;

  // Held off while in reset so the BRAM contents are never disturbed.
  assign fire     = RST_N && REQ_VALID && REQ_READY;
  assign fire_rsp = fire && responding;

  assign BRAM_EN   = fire;
  assign BRAM_WE   = fire && REQ_WRITE;
  assign BRAM_ADDR = REQ_ADDR;
  assign BRAM_DI   = REQ_DATA;

  assign trk_last = trk[LAT-1];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign deq      = !empty && RSP_READY;

`ifdef BRAM_READ_SERVER_BYPASS_EN
  assign RSP_VALID = !empty || trk_last;
  assign RSP_DATA  = empty ? BRAM_DO : mem[rd_ptr];
  assign enq       = trk_last && !(empty && RSP_READY);
`else
  assign RSP_VALID = !empty;
  assign RSP_DATA  = mem[rd_ptr];
  assign enq       = trk_last;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      trk    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      trk <= LAT'({trk, fire_rsp});
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      if (enq && !deq)      count <= count + CW'(1);
      else if (!enq && deq) count <= count - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) mem[wr_ptr] <= BRAM_DO;
  end

  assert property (@(posedge CLK) disable iff (!RST_N) !(enq && full && !deq));

endmodule

// File: tb/tb_bram_read_server.sv
// Directed self-checking bench for bram_read_server with a behavioural write-first BRAM port (LAT=2).
module tb_bram_read_server;

  localparam int AW   = 4;
  localparam int DW   = 16;
  localparam int PIPE = 1;
  localparam int DEP  = 3;
  localparam int LAT  = 2;
`ifdef BRAM_READ_SERVER_BYPASS_EN
  localparam int RLAT = LAT;
`else
  localparam int RLAT = LAT + 1;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic          REQ_WRITE = 1'b0;
  logic [AW-1:0] REQ_ADDR = '0;
  logic [DW-1:0] REQ_DATA = '0;
  logic          RSP_VALID;
  logic          RSP_READY = 1'b0;
  logic [DW-1:0] RSP_DATA;
  logic          BRAM_EN, BRAM_WE;
  logic [AW-1:0] BRAM_ADDR;
  logic [DW-1:0] BRAM_DI, BRAM_DO;

  int vectors = 0;
  int miscompares = 0;

  bram_read_server #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPELINED(PIPE), .DEPTH(DEP), .RESPONSE_ON_WRITE(0)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
    .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_ADDR(BRAM_ADDR),
    .BRAM_DI(BRAM_DI), .BRAM_DO(BRAM_DO)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 3) return 16'h00A5;
    return 16'h1100 + DW'(a);
  endfunction

  // Write-first BRAM port with optional output register.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] do_r = '0;
  logic [DW-1:0] do_p = '0;
  logic          loaded = 1'b0;
  always @(posedge CLK) begin
    if (!loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
      loaded <= 1'b1;
    end else if (BRAM_EN) begin
      if (BRAM_WE) begin
        mem[BRAM_ADDR] <= BRAM_DI;
        do_r <= BRAM_DI;
      end else begin
        do_r <= mem[BRAM_ADDR];
      end
    end
    do_p <= do_r;
  end
  assign BRAM_DO = (PIPE != 0) ? do_p : do_r;

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; REQ_VALID = 1'b0; RSP_READY = 1'b0;
    next_cycle();
    next_cycle();
    RST_N = 1'b1;
    @(negedge CLK);
    vectors++;
    if (RSP_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0", RSP_VALID); end
    vectors++;
    if (REQ_READY !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 1", REQ_READY); end
    vectors++;
    if (BRAM_EN !== 1'b0) begin miscompares++; $display("FAIL reset_bram_en: got %b expected 0", BRAM_EN); end
    vectors++;
    if (BRAM_WE !== 1'b0) begin miscompares++; $display("FAIL reset_bram_we: got %b expected 0", BRAM_WE); end
    next_cycle();
  endtask

  task automatic test_single_read();
    int first = -1;
    int nrsp = 0;
    logic [DW-1:0] got = '0;
    REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 4'd3; REQ_DATA = 16'h5A5A; RSP_READY = 1'b1;
    @(negedge CLK);
    vectors++;
    if (BRAM_EN !== 1'b1 || BRAM_WE !== 1'b0) begin
      miscompares++; $display("FAIL read_bram_ctl: got en=%b we=%b expected en=1 we=0", BRAM_EN, BRAM_WE);
    end
    vectors++;
    if (BRAM_ADDR !== 4'd3 || BRAM_DI !== 16'h5A5A) begin
      miscompares++; $display("FAIL read_bram_pins: got addr=%0h di=%0h expected addr=3 di=5a5a", BRAM_ADDR, BRAM_DI);
    end
    next_cycle();
    REQ_VALID = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (RSP_VALID) begin
        nrsp++;
        if (first < 0) begin first = k; got = RSP_DATA; end
      end
      next_cycle();
    end
    vectors++;
    if (first != RLAT) begin miscompares++; $display("FAIL read_latency: got %0d expected %0d", first, RLAT); end
    vectors++;
    if (got !== 16'h00A5) begin miscompares++; $display("FAIL read_data: got %0h expected a5", got); end
    vectors++;
    if (nrsp != 1) begin miscompares++; $display("FAIL read_rsp_count: got %0d expected 1", nrsp); end
  endtask

  task automatic test_back_to_back();
    int sent = 0, rcv = 0, first_fire = -1, first_rsp = -1, last_rsp = -1, drops = 0, gaps = 0;
    RSP_READY = 1'b1;
    REQ_WRITE = 1'b0;
    for (int c = 0; c < 60 && rcv < 8; c++) begin
      REQ_VALID = (sent < 8);
      REQ_ADDR  = AW'(sent);
      @(negedge CLK);
      if (REQ_VALID && !REQ_READY) drops++;
      if (REQ_VALID && REQ_READY) begin
        if (first_fire < 0) first_fire = c;
        sent++;
      end
      if (RSP_VALID) begin
        vectors++;
        if (RSP_DATA !== init_val(rcv)) begin
          miscompares++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", rcv, RSP_DATA, init_val(rcv));
        end
        if (first_rsp < 0) first_rsp = c;
        else if (c != last_rsp + 1) gaps++;
        last_rsp = c;
        rcv++;
      end
      next_cycle();
    end
    REQ_VALID = 1'b0;
    vectors++;
    if (rcv != 8) begin miscompares++; $display("FAIL b2b_count: got %0d expected 8", rcv); end
    vectors++;
    if (first_rsp - first_fire != RLAT) begin
      miscompares++; $display("FAIL b2b_first_latency: got %0d expected %0d", first_rsp - first_fire, RLAT);
    end
`ifdef BRAM_READ_SERVER_BYPASS_EN
    vectors++;
    if (drops != 0) begin miscompares++; $display("FAIL b2b_ready_drops: got %0d expected 0", drops); end
    vectors++;
    if (gaps != 0) begin miscompares++; $display("FAIL b2b_rsp_gaps: got %0d expected 0", gaps); end
`endif
  endtask

  task automatic test_backpressure();
    int acc = 0, rcv = 0;
    RSP_READY = 1'b0;
    REQ_WRITE = 1'b0;
    for (int c = 0; c < 8; c++) begin
      REQ_VALID = (acc < 5);
      REQ_ADDR  = AW'(8 + acc);
      @(negedge CLK);
      if (REQ_VALID && REQ_READY) acc++;
      next_cycle();
    end
    vectors++;
    if (acc != 3) begin miscompares++; $display("FAIL bp_accepted: got %0d expected 3", acc); end
    @(negedge CLK);
    vectors++;
    if (REQ_READY !== 1'b0) begin miscompares++; $display("FAIL bp_ready_full: got %b expected 0", REQ_READY); end
    next_cycle();
    RSP_READY = 1'b1;
    @(negedge CLK);
    vectors++;
    if (REQ_READY !== 1'b0) begin miscompares++; $display("FAIL bp_ready_same_cycle: got %b expected 0", REQ_READY); end
    if (REQ_VALID && REQ_READY) acc++;
    if (RSP_VALID) begin
      vectors++;
      if (RSP_DATA !== init_val(8 + rcv)) begin
        miscompares++; $display("FAIL bp_data[%0d]: got %0h expected %0h", rcv, RSP_DATA, init_val(8 + rcv));
      end
      rcv++;
    end
    next_cycle();
    @(negedge CLK);
    vectors++;
    if (REQ_READY !== 1'b1) begin miscompares++; $display("FAIL bp_ready_after_deq: got %b expected 1", REQ_READY); end
    if (REQ_VALID && REQ_READY) acc++;
    if (RSP_VALID) begin
      vectors++;
      if (RSP_DATA !== init_val(8 + rcv)) begin
        miscompares++; $display("FAIL bp_data[%0d]: got %0h expected %0h", rcv, RSP_DATA, init_val(8 + rcv));
      end
      rcv++;
    end
    next_cycle();
    for (int c = 0; c < 40 && rcv < 5; c++) begin
      REQ_VALID = (acc < 5);
      REQ_ADDR  = AW'(8 + acc);
      @(negedge CLK);
      if (REQ_VALID && REQ_READY) acc++;
      if (RSP_VALID) begin
        vectors++;
        if (RSP_DATA !== init_val(8 + rcv)) begin
          miscompares++; $display("FAIL bp_data[%0d]: got %0h expected %0h", rcv, RSP_DATA, init_val(8 + rcv));
        end
        rcv++;
      end
      next_cycle();
    end
    REQ_VALID = 1'b0;
    vectors++;
    if (rcv != 5 || acc != 5) begin
      miscompares++; $display("FAIL bp_total: got rsp=%0d acc=%0d expected 5 and 5", rcv, acc);
    end
  endtask

  task automatic test_write_no_rsp();
    int acc = 0, rcv = 0, nrsp = 0;
    logic [DW-1:0] got = '0;
    RSP_READY = 1'b0;
    REQ_WRITE = 1'b0;
    for (int c = 0; c < 6; c++) begin
      REQ_VALID = (acc < 3);
      REQ_ADDR  = AW'(acc);
      @(negedge CLK);
      if (REQ_VALID && REQ_READY) acc++;
      next_cycle();
    end
    REQ_VALID = 1'b0;
    @(negedge CLK);
    vectors++;
    if (REQ_READY !== 1'b0) begin miscompares++; $display("FAIL wr_read_blocked: got %b expected 0", REQ_READY); end
    next_cycle();
    REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_ADDR = 4'd7; REQ_DATA = 16'h003C;
    @(negedge CLK);
    vectors++;
    if (REQ_READY !== 1'b1 || BRAM_WE !== 1'b1) begin
      miscompares++; $display("FAIL wr_accept: got ready=%b we=%b expected 1 and 1", REQ_READY, BRAM_WE);
    end
    next_cycle();
    REQ_VALID = 1'b0; REQ_WRITE = 1'b0;
    RSP_READY = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (RSP_VALID) begin
        vectors++;
        if (RSP_DATA !== init_val(rcv)) begin
          miscompares++; $display("FAIL wr_drain_data[%0d]: got %0h expected %0h", rcv, RSP_DATA, init_val(rcv));
        end
        rcv++;
      end
      next_cycle();
    end
    vectors++;
    if (rcv != 3) begin miscompares++; $display("FAIL wr_no_response: got %0d responses expected 3", rcv); end
    REQ_VALID = 1'b1; REQ_ADDR = 4'd7;
    next_cycle();
    REQ_VALID = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (RSP_VALID) begin
        if (nrsp == 0) got = RSP_DATA;
        nrsp++;
      end
      next_cycle();
    end
    vectors++;
    if (nrsp != 1 || got !== 16'h003C) begin
      miscompares++; $display("FAIL wr_readback: got count=%0d data=%0h expected 1 and 3c", nrsp, got);
    end
  endtask

  task automatic test_reset_midflight();
    int spurious = 0;
    RSP_READY = 1'b1; REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 4'd2;
    @(negedge CLK);
    vectors++;
    if (REQ_READY !== 1'b1) begin miscompares++; $display("FAIL mid_accept: got %b expected 1", REQ_READY); end
    next_cycle();
    REQ_VALID = 1'b0;
    RST_N = 1'b0;
    next_cycle();
    RST_N = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (RSP_VALID) spurious++;
      next_cycle();
    end
    vectors++;
    if (spurious != 0) begin miscompares++; $display("FAIL mid_spurious: got %0d responses expected 0", spurious); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_backpressure();
    test_write_no_rsp();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
